// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA raster generator: pattern modes,
// default 640x480@60 timing and the colour-bar table.
package vga_pkg;

   typedef enum logic [1:0] {PASS, BARS, CHECK, PRODUCT} vga_mode_t;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   // {r,g,b} on/off per bar, left to right
   localparam logic [0:7][2:0] BAR_RGB = {
      3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
   };

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of the VGA raster generator: upstream pixel/mode inputs,
// raster coordinates/strobes and the connector pins.
interface vga_timing_gen_if #(
   parameter int CW = 4
);
   import vga_pkg::*;

   logic          pix_en;
   vga_mode_t     mode;
   logic [CW-1:0] pix_r, pix_g, pix_b;
   logic [9:0]    x_o, y_o;
   logic          de_o, line_start_o, frame_start_o;
   logic [15:0]   frame_cnt_o;
   logic [CW-1:0] vga_r, vga_g, vga_b;
   logic          vga_hs, vga_vs;

   modport master (
      input  pix_en, mode, pix_r, pix_g, pix_b,
      output x_o, y_o, de_o, line_start_o, frame_start_o, frame_cnt_o,
             vga_r, vga_g, vga_b, vga_hs, vga_vs
   );

   modport slave (
      output pix_en, mode, pix_r, pix_g, pix_b,
      input  x_o, y_o, de_o, line_start_o, frame_start_o, frame_cnt_o,
             vga_r, vga_g, vga_b, vga_hs, vga_vs
   );

endinterface

// File: rtl/vga_pattern_gen.sv
// Test-pattern colour stage: one register from the coordinate stage to the pins.
// Modes: pass-through, colour bars, checkerboard, x*y product pattern.
module vga_pattern_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int CW       = 4,
   parameter int CHK_LOG2 = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pix_en,
   input  logic [9:0]    x_p1,
   input  logic [9:0]    y_p1,
   input  logic          de_p1,
   input  vga_mode_t     mode_p1,
   input  logic [CW-1:0] pix_r,
   input  logic [CW-1:0] pix_g,
   input  logic [CW-1:0] pix_b,
   output logic [CW-1:0] r_p2,
   output logic [CW-1:0] g_p2,
   output logic [CW-1:0] b_p2
);

   localparam logic [9:0]    BAR_LAST = 10'(H_ACTIVE / 8 - 1);
   localparam logic [CW-1:0] ONES     = '1;

   function automatic logic [CW-1:0] fit_cw(input logic [3:0] v);
      return CW'(v);
   endfunction

   logic [9:0]    sub_q, sub_c;
   logic [2:0]    idx_q, idx_c, bar;
   logic [CW-1:0] prod;
   logic [CW-1:0] r_c, g_c, b_c;

   assign prod = CW'(x_p1 * y_p1);

   // sub_q/idx_q track the bar of the previous x; x steps by one per enabled cycle
   always_comb begin
      sub_c = sub_q + 10'd1;
      idx_c = idx_q;
      if (x_p1 == '0) begin
         sub_c = '0;
         idx_c = '0;
      end else if (sub_q == BAR_LAST) begin
         sub_c = '0;
         idx_c = idx_q + 3'd1;
      end
      bar = BAR_RGB[idx_c];
      r_c = '0;
      g_c = '0;
      b_c = '0;
      if (de_p1) begin
         case (mode_p1)
            BARS: begin
               r_c = {CW{bar[2]}};
               g_c = {CW{bar[1]}};
               b_c = {CW{bar[0]}};
            end
            CHECK: begin
               if (x_p1[CHK_LOG2] ^ y_p1[CHK_LOG2]) begin
                  r_c = ONES;
                  g_c = ONES;
                  b_c = ONES;
               end
            end
            PRODUCT: begin
               r_c = prod;
               g_c = fit_cw({x_p1[3:2], y_p1[1:0]});
               b_c = prod;
            end
            default: begin
               r_c = pix_r;
               g_c = pix_g;
               b_c = pix_b;
            end
         endcase
      end
   end

   // stage p1 -> p2
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sub_q <= '0;
         idx_q <= '0;
         r_p2  <= '0;
         g_p2  <= '0;
         b_p2  <= '0;
      end else if (pix_en) begin
         sub_q <= sub_c;
         idx_q <= idx_c;
         r_p2  <= r_c;
         g_p2  <= g_c;
         b_p2  <= b_c;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: counters, registered coordinates/strobes, sync pins.
// Define VGA_TPG_EN to build in the test-pattern generator; otherwise pix_* pass through gated by de.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CW       = 4,
   parameter int CHK_LOG2 = 5
) (
   input logic               clk,
   input logic               rst,
   vga_timing_gen_if.master  vif
);

   localparam int         H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int         V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [9:0]    hc, vc;
   logic          h_wrap, f_wrap, de_c, hs_c, vs_c;
   logic [9:0]    x_p1, y_p1;
   logic          de_p1, ls_p1, fs_p1, hs_p1, vs_p1;
   logic [15:0]   frame_cnt_p1;
   logic          hs_p2, vs_p2;
   logic [CW-1:0] r_p2, g_p2, b_p2;

   assign h_wrap = (hc == H_LAST);
   assign f_wrap = h_wrap && (vc == V_LAST);
   assign de_c   = (hc < H_ACT) && (vc < V_ACT);
   assign hs_c   = (hc >= HS_BEG) && (hc < HS_END);
   assign vs_c   = (vc >= VS_BEG) && (vc < VS_END);

   // stage p0: raster counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hc <= '0;
         vc <= '0;
      end else if (vif.pix_en) begin
         if (h_wrap) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
         end else begin
            hc <= hc + 10'd1;
         end
      end
   end

   // stage p0 -> p1: coordinates, strobes, decoded sync
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_p1  <= '0;
         y_p1  <= '0;
         de_p1 <= 1'b0;
         ls_p1 <= 1'b0;
         fs_p1 <= 1'b0;
         hs_p1 <= 1'b0;
         vs_p1 <= 1'b0;
      end else if (vif.pix_en) begin
         x_p1  <= hc;
         y_p1  <= vc;
         de_p1 <= de_c;
         ls_p1 <= (hc == '0);
         fs_p1 <= (hc == '0) && (vc == '0);
         hs_p1 <= hs_c;
         vs_p1 <= vs_c;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         frame_cnt_p1 <= '0;
      else if (vif.pix_en && f_wrap)
         frame_cnt_p1 <= frame_cnt_p1 + 16'd1;
   end

   // stage p1 -> p2: sync pins, matching the colour register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hs_p2 <= ~HS_POL;
         vs_p2 <= ~VS_POL;
      end else if (vif.pix_en) begin
         hs_p2 <= hs_p1 ? HS_POL : ~HS_POL;
         vs_p2 <= vs_p1 ? VS_POL : ~VS_POL;
      end
   end

`ifdef VGA_TPG_EN
   vga_mode_t mode_p1;

   // mode is taken at the edge that raises frame_start_o, so (0,0) already uses it
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         mode_p1 <= PASS;
      else if (vif.pix_en && hc == '0 && vc == '0)
         mode_p1 <= vif.mode;
   end

   vga_pattern_gen #(
      .H_ACTIVE (H_ACTIVE),
      .CW       (CW),
      .CHK_LOG2 (CHK_LOG2)
   ) u_pattern (
      .clk     (clk),
      .rst     (rst),
      .pix_en  (vif.pix_en),
      .x_p1    (x_p1),
      .y_p1    (y_p1),
      .de_p1   (de_p1),
      .mode_p1 (mode_p1),
      .pix_r   (vif.pix_r),
      .pix_g   (vif.pix_g),
      .pix_b   (vif.pix_b),
      .r_p2    (r_p2),
      .g_p2    (g_p2),
      .b_p2    (b_p2)
   );
`else
   logic unused_mode;
   assign unused_mode = ^vif.mode;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_p2 <= '0;
         g_p2 <= '0;
         b_p2 <= '0;
      end else if (vif.pix_en) begin
         r_p2 <= de_p1 ? vif.pix_r : '0;
         g_p2 <= de_p1 ? vif.pix_g : '0;
         b_p2 <= de_p1 ? vif.pix_b : '0;
      end
   end
`endif

   assign vif.x_o           = x_p1;
   assign vif.y_o           = y_p1;
   assign vif.de_o          = de_p1;
   assign vif.line_start_o  = ls_p1;
   assign vif.frame_start_o = fs_p1;
   assign vif.frame_cnt_o   = frame_cnt_p1;
   assign vif.vga_hs        = hs_p2;
   assign vif.vga_vs        = vs_p2;
   assign vif.vga_r         = r_p2;
   assign vif.vga_g         = g_p2;
   assign vif.vga_b         = b_p2;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 24x8 raster (16x4 active), CW=4, CHK_LOG2=1.
// Each pixel-enabled cycle is checked against the raster position the bench expects.
module tb_vga_timing_gen;
   import vga_pkg::*;

   localparam int HT = 24;
   localparam int VT = 8;
   localparam int FT = HT * VT;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int   n_chk = 0;
   int   n_err = 0;
   int   k = 0;
   int   de_cnt = 0, hs_low = 0, vs_low = 0, since_ls = 0, hs_run = 0;
   logic prev_hs = 1'b1;

   vga_mode_t   frm_mode [8];
   logic [11:0] bar_tab  [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                 12'hF0F, 12'hF00, 12'h00F, 12'h000};

   vga_timing_gen_if #(.CW(4)) vif ();

   vga_timing_gen #(
      .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
      .V_ACTIVE (4),  .V_FP (1), .V_SYNC (2), .V_BP (1),
      .HS_POL   (1'b0), .VS_POL (1'b0), .CW (4), .CHK_LOG2 (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .vif (vif.master)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (k=%0d)", tag, got, exp, k);
      end
   endtask

   // {r,g,b} expected on the pins for raster position (x,y)
   function automatic logic [11:0] exp_rgb(input int x, input int y, input vga_mode_t m);
      logic [3:0] xv, yv, pr;
      xv = 4'(x);
      yv = 4'(y);
      pr = 4'(x * y);
      if (!(x < 16 && y < 4)) return 12'h000;
`ifdef VGA_TPG_EN
      case (m)
         BARS:    return bar_tab[x / 2];
         CHECK:   return (xv[1] ^ yv[1]) ? 12'hFFF : 12'h000;
         PRODUCT: return {pr, xv[3:2], yv[1:0], pr};
         default: return {xv, yv, 4'hA};
      endcase
`else
      return {xv, yv, 4'hA};
`endif
   endfunction

   task automatic check_cycle();
      int s1, s2, x1, y1, x2, y2;
      logic [22:0] e1;
      logic [13:0] e2;
      if (k == 0) begin
         e1 = '0;
      end else begin
         s1 = k - 1;
         x1 = s1 % HT;
         y1 = (s1 / HT) % VT;
         e1 = {10'(x1), 10'(y1), (x1 < 16 && y1 < 4), (x1 == 0), (x1 == 0 && y1 == 0)};
      end
      if (k < 2) begin
         e2 = {1'b1, 1'b1, 12'h000};
      end else begin
         s2 = k - 2;
         x2 = s2 % HT;
         y2 = (s2 / HT) % VT;
         e2 = {!(x2 >= 18 && x2 < 21), !(y2 >= 5 && y2 < 7),
               exp_rgb(x2, y2, frm_mode[(s2 / FT) % 8])};
      end
      check_eq("stage1", {vif.x_o, vif.y_o, vif.de_o, vif.line_start_o, vif.frame_start_o}, e1);
      check_eq("pins", {vif.vga_hs, vif.vga_vs, vif.vga_r, vif.vga_g, vif.vga_b}, e2);
   endtask

   task automatic step();
      logic adv;
      adv = vif.pix_en && !rst;
      if (adv && (k % FT == 0)) frm_mode[(k / FT) % 8] = vif.mode;
      @(negedge clk);
      if (adv) k++;
      check_cycle();
      if (adv) begin
         if (vif.de_o) de_cnt++;
         if (!vif.vga_hs) hs_low++;
         if (!vif.vga_vs) vs_low++;
         since_ls++;
         if (vif.line_start_o) since_ls = 0;
         // hs pin trails line_start_o by 18 pixels plus the colour-matching stage
         if (prev_hs && !vif.vga_hs) check_eq("hs_offset", since_ls, 19);
         if (!vif.vga_hs) hs_run++;
         if (!prev_hs && vif.vga_hs) begin
            check_eq("hs_width", hs_run, 3);
            hs_run = 0;
         end
         prev_hs = vif.vga_hs;
      end
      vif.pix_r = vif.x_o[3:0];
      vif.pix_g = vif.y_o[3:0];
   endtask

   task automatic run_to(input int target);
      while (k < target) step();
   endtask

   initial begin
      vif.pix_en = 1'b1;
      vif.mode   = BARS;
      vif.pix_r  = '0;
      vif.pix_g  = '0;
      vif.pix_b  = 4'hA;
      for (int i = 0; i < 8; i++) frm_mode[i] = PASS;

      repeat (3) step();
      check_eq("rst_fcnt", vif.frame_cnt_o, 0);
      rst = 1'b0;
      step();
      check_eq("first_fs", vif.frame_start_o, 1);

      run_to(2 * HT + 1);
      vif.mode = CHECK;
      run_to(FT);
      check_eq("fcnt_1", vif.frame_cnt_o, 1);
      run_to(FT + 2 * HT + 1);
      vif.mode = PRODUCT;
      run_to(2 * FT + 2 * HT + 1);
      vif.mode = PASS;
      run_to(3 * FT);
      check_eq("fcnt_3", vif.frame_cnt_o, 3);
      check_eq("de_count", de_cnt, 3 * 64);
      check_eq("hs_low_count", hs_low, 3 * 8 * 3);
      check_eq("vs_low_count", vs_low, 3 * 48);

      run_to(3 * FT + HT + 8);
      check_eq("stall_x_pre", vif.x_o, 7);
      vif.pix_en = 1'b0;
      repeat (5) begin
         step();
         check_eq("stall_x", vif.x_o, 7);
      end
      vif.pix_en = 1'b1;
      step();
      check_eq("resume_x", vif.x_o, 8);

      run_to(3 * FT + 100);
      force dut.frame_cnt_p1 = 16'hFFFF;
      release dut.frame_cnt_p1;
      #1;
      check_eq("fcnt_forced", vif.frame_cnt_o, 16'hFFFF);
      run_to(4 * FT);
      check_eq("fcnt_wrap", vif.frame_cnt_o, 0);

      run_to(4 * FT + HT + 11);
      check_eq("pre_rst_xy", {vif.x_o, vif.y_o}, {10'd10, 10'd1});
      rst = 1'b1;
      #1;
      check_eq("mid_rst_xy", {vif.x_o, vif.y_o}, 0);
      check_eq("mid_rst_strobes", {vif.de_o, vif.line_start_o, vif.frame_start_o}, 0);
      check_eq("mid_rst_sync", {vif.vga_hs, vif.vga_vs}, 2'b11);
      check_eq("mid_rst_rgb", {vif.vga_r, vif.vga_g, vif.vga_b}, 0);
      check_eq("mid_rst_fcnt", vif.frame_cnt_o, 0);
      k = 0;
      since_ls = 0;
      hs_run = 0;
      prev_hs = 1'b1;
      for (int i = 0; i < 8; i++) frm_mode[i] = PASS;
      repeat (2) step();
      vif.mode = BARS;
      rst = 1'b0;
      step();
      check_eq("fs_after_rst", vif.frame_start_o, 1);
      run_to(FT + 2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster generator: successor to the fixed 640x480 video block, placed between the pixel-clock domain output of the clock wizard and the VGA connector pins. All timing (active, porches, sync widths, sync polarity) and colour depth are parameters. It has a pixel-enable input, registered coordinate/data-enable outputs for downstream pixel sources, and frame/line strobes. An optional built-in test-pattern generator has run-time selectable modes that switch only on frame boundaries.

## Interface
- `H_ACTIVE`, 640, visible pixels per line (multiple of 8)
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines; `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33
- `HS_POL`, 0, active level of hsync (0 = active-low)
- `VS_POL`, 0, active level of vsync
- `CW`, 4, bits per colour channel
- `CHK_LOG2`, 5, checkerboard square size = 2^CHK_LOG2 pixels

- `clk` in 1: pixel clock (25 MHz for default timing)
- `rst` in 1: asynchronous, active-high reset
- `pix_en` in 1: advance raster this cycle; when low all state holds
- `mode` in 2: pattern select (0 pass-through, 1 colour bars, 2 checkerboard, 3 product pattern)
- `pix_r`, `pix_g`, `pix_b` in CW each: upstream pixel for mode 0, sampled against `x_o`/`y_o`
- `x_o` out 10: current column; `y_o` out 10: current row
- `de_o` out 1: pixel is in the active area
- `line_start_o` out 1: one-cycle strobe at x=0 of every line
- `frame_start_o` out 1: one-cycle strobe at (0,0)
- `frame_cnt_o` out 16: frames completed, wraps modulo 2^16
- `vga_r`, `vga_g`, `vga_b` out CW each: colour to pins
- `vga_hs`, `vga_vs` out 1: sync pins

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is the vertical equivalent.
- Counters: `hc` counts 0..H_TOTAL-1. `vc` increments when `hc` wraps and counts 0..V_TOTAL-1. Both advance only when `pix_en`=1.
- Decode from the counter state:
  - de = hc<H_ACTIVE && vc<V_ACTIVE.
  - hs active for H_ACTIVE+H_FP ≤ hc < H_ACTIVE+H_FP+H_SYNC, exactly H_SYNC clocks.
  - vs active for the analogous range in `vc`, exactly V_SYNC lines, switching at hc=0.
- Active sync level is driven as HS_POL/VS_POL; the inactive level is its inverse.
- Outside the active area, `vga_r/g/b` are 0 in every mode.
- `mode` is captured into an internal register only when `frame_start_o` fires, so the pattern never changes mid-frame.
- Pattern modes:
  - Mode 0 passes `pix_*` through.
  - Mode 1 draws 8 equal vertical bars: white, yellow, cyan, green, magenta, red, blue, black. Each channel is all-ones or 0. The bar index comes from an internal sub-counter reloaded every H_ACTIVE/8 pixels; no divider is used.
  - Mode 2: white when x[CHK_LOG2]^y[CHK_LOG2] is 1, else black.
  - Mode 3: r = b = (x*y)[CW-1:0], g = {x[3:2], y[1:0]} resized to CW.
- `frame_cnt_o` increments when `vc` and `hc` both wrap.

## Timing
- All outputs are registered; every output is aligned to the same counter state with 1 cycle latency after the counter register.
- In mode 0, `pix_*` are sampled in the cycle `x_o`/`y_o` are presented and appear on `vga_*` 1 cycle later. Sync and `de` are delayed by one matching stage internally, so pins stay aligned. Pin latency is 2 clocks from counter state.
- Reset values: hc=vc=0, `x_o`=`y_o`=0, `de_o`=0, strobes=0, `frame_cnt_o`=0, colour=0, `vga_hs`=~HS_POL, `vga_vs`=~VS_POL, latched mode=0.
- The first `frame_start_o` occurs on the first `pix_en` cycle after reset release.
- Reset mid-frame aborts the frame: counters return to 0 immediately (async) and sync goes inactive.
- `pix_en`=0 freezes the counters and all output registers, including the strobes. A strobe held high during a freeze is still counted as one event.
- When frame end and a `mode` change coincide, the new mode applies starting at pixel (0,0) of the next frame.

## Configuration
- `VGA_TPG_EN` defined: modes 1–3 are implemented as above.
- `VGA_TPG_EN` undefined: the pattern logic is removed and `mode` is ignored. `vga_r/g/b` always pass `pix_*`, gated by de. Latency is unchanged.

## Structure
- Package `vga_pkg`:
  - typedef enum `vga_mode_t` {PASS, BARS, CHECK, PRODUCT}
  - default 640x480@60 timing localparams
  - bar colour constant table
- Sub-module `vga_pattern_gen` produces colour from (x, y, de, latched mode, pix_*) with one register stage. It is instantiated only under `VGA_TPG_EN`.

## Test plan
Small timing is used for speed: H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL=24); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8); CW=4.
- **Reset and sync timing:** hold rst, then release with pix_en=1.
  - During reset, hs/vs sit at their inactive level.
  - First frame_start_o at cycle 1.
  - hs active for exactly 3 clocks starting 18 cycles after line_start_o.
  - vs active for 2 lines (48 clocks).
- **Frame count:** run 3 frames (576 clocks) → frame_cnt_o=3 and de_o high for 64 cycles per frame. Force frame_cnt to 0xFFFF → it wraps to 0.
- **Colour bars:** mode=1 → bars are 2 pixels wide; pixels 0–1 are F/F/F, pixels 14–15 are 0/0/0, and blanking is 0.
- **Mid-frame mode change:** switch mode 1→2 at y=2 → the rest of the frame stays bars, and the checkerboard starts at the next frame_start_o.
- **pix_en stall:** pix_en low for 5 cycles at x=7 → x_o holds 7 and no sync edges occur; counting resumes at 8.
- **Mode 0 latency:** with `VGA_TPG_EN` undefined, pix_r = x_o[3:0] → vga_r equals the x value one clock later, aligned with de.
- **Reset mid-line:** rst pulse at x=10, y=1 → outputs return immediately to their reset values, and a new frame_start_o appears on the first pix_en cycle after release.
